// File: rtl/player_pkg.sv
// Shared types and constants for the player action controller: state and
// attack-phase encodings, HID keycodes and a 10-bit negate helper.
package player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_RISE = 3'd2,
      ST_FALL = 3'd3
   } player_state_t;

   typedef enum logic [1:0] {
      PH_READY = 2'd0,
      PH_SWING = 2'd1,
      PH_COOL  = 2'd2
   } atk_phase_t;

   localparam logic [7:0] KEY_LEFT   = 8'h50;
   localparam logic [7:0] KEY_RIGHT  = 8'h4F;
   localparam logic [7:0] KEY_JUMP   = 8'h52;
   localparam logic [7:0] KEY_ATTACK = 8'h1B;

   function automatic logic [9:0] neg10(input logic [9:0] v);
      return ~v + 10'd1;
   endfunction

endpackage

// File: rtl/player_action_ctrl_attack_timer.sv
// Attack swing/cooldown sequencer: READY -> SWING -> COOL -> READY, with one
// shared down-counter timing both the swing and the cooldown.
module attack_timer
   import player_pkg::*;
#(
   parameter int ATTACK_FRAMES   = 12,
   parameter int ATTACK_COOLDOWN = 20
) (
   input  logic frame_clk,
   input  logic Reset,
   input  logic start,
   output logic attack,
   output logic busy
);

   localparam int MAXC = (ATTACK_FRAMES > ATTACK_COOLDOWN) ? ATTACK_FRAMES : ATTACK_COOLDOWN;
   localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

   atk_phase_t     phase, phase_d;
   logic [CW-1:0]  cnt, cnt_d;

   // Counter holds the frames remaining in the current phase, including this one.
   always_comb begin
      phase_d = phase;
      cnt_d   = cnt;
      case (phase)
         PH_READY: begin
            if (start) begin
               phase_d = PH_SWING;
               cnt_d   = CW'(ATTACK_FRAMES);
            end
         end
         PH_SWING: begin
            if (cnt <= CW'(1)) begin
               if (ATTACK_COOLDOWN == 0) begin
                  phase_d = PH_READY;
                  cnt_d   = '0;
               end else begin
                  phase_d = PH_COOL;
                  cnt_d   = CW'(ATTACK_COOLDOWN);
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         PH_COOL: begin
            if (cnt <= CW'(1)) begin
               phase_d = PH_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: begin
            phase_d = PH_READY;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         phase  <= PH_READY;
         cnt    <= '0;
         attack <= 1'b0;
      end else begin
         phase  <= phase_d;
         cnt    <= cnt_d;
         attack <= (phase_d == PH_SWING);
      end
   end

   assign busy = (phase != PH_READY);

endmodule

// File: rtl/player_action_ctrl.sv
// Frame-rate player controller: keycode edge detect, IDLE/RUN/RISE/FALL FSM,
// attack timer and registered motion commands. Optional double jump: PLAYER_DOUBLE_JUMP_EN.
module player_action_ctrl
   import player_pkg::*;
#(
   parameter int RUN_STEP        = 2,
   parameter int RISE_STEP       = 4,
   parameter int FALL_STEP       = 4,
   parameter int JUMP_FRAMES     = 24,
   parameter int ATTACK_FRAMES   = 12,
   parameter int ATTACK_COOLDOWN = 20
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       on_ground,
   input  logic       hit_ceiling,
   output logic [9:0] x_motion,
   output logic [9:0] y_motion,
   output logic       facing_left,
   output logic       attack,
   output logic [2:0] state
);

   localparam int         JCW      = $clog2(JUMP_FRAMES + 1);
   localparam logic [9:0] RUN_POS  = 10'(RUN_STEP);
   localparam logic [9:0] RISE_POS = 10'(RISE_STEP);
   localparam logic [9:0] FALL_POS = 10'(FALL_STEP);

   player_state_t  cur_st, nxt_st;
   logic [JCW-1:0] jump_cnt, jcnt_d;
   logic [9:0]     x_d, y_d;
   logic           face_d;
   logic           prev_jump, prev_atk, armed;
   logic           key_left, key_right, key_jump, key_atk;
   logic           jump_press, atk_press, atk_busy, dj_take;

   assign key_left  = (keycode == KEY_LEFT);
   assign key_right = (keycode == KEY_RIGHT);
   assign key_jump  = (keycode == KEY_JUMP);
   assign key_atk   = (keycode == KEY_ATTACK);

   // armed stays low for the first frame after reset so a key held through
   // reset is learned as "already down" rather than seen as a fresh press.
   assign jump_press = armed && key_jump && !prev_jump;
   assign atk_press  = armed && key_atk  && !prev_atk;

   assign state = cur_st;

`ifdef PLAYER_DOUBLE_JUMP_EN
   logic dj_used;

   assign dj_take = jump_press && !dj_used &&
                    (((cur_st == ST_RISE) && !hit_ceiling) ||
                     ((cur_st == ST_FALL) && !on_ground));

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)          dj_used <= 1'b0;
      else if (on_ground) dj_used <= 1'b0;
      else if (dj_take)   dj_used <= 1'b1;
   end
`else
   assign dj_take = 1'b0;
`endif

   attack_timer #(
      .ATTACK_FRAMES   (ATTACK_FRAMES),
      .ATTACK_COOLDOWN (ATTACK_COOLDOWN)
   ) u_attack_timer (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .start     (atk_press && !atk_busy),
      .attack    (attack),
      .busy      (atk_busy)
   );

   always_comb begin
      nxt_st = cur_st;
      jcnt_d = jump_cnt;
      case (cur_st)
         ST_IDLE, ST_RUN: begin
            if (!on_ground) begin
               nxt_st = ST_FALL;
            end else if (jump_press) begin
               nxt_st = ST_RISE;
               jcnt_d = JCW'(JUMP_FRAMES);
            end else if (key_left || key_right) begin
               nxt_st = ST_RUN;
            end else begin
               nxt_st = ST_IDLE;
            end
         end
         ST_RISE: begin
            jcnt_d = (jump_cnt != '0) ? jump_cnt - 1'b1 : '0;
            if (hit_ceiling) begin
               nxt_st = ST_FALL;
            end else if (dj_take) begin
               jcnt_d = JCW'(JUMP_FRAMES);
            end else if (jump_cnt <= JCW'(1)) begin
               nxt_st = ST_FALL;
            end
         end
         ST_FALL: begin
            // Landing outranks any jump pressed on the same frame.
            if (on_ground) begin
               nxt_st = ST_IDLE;
            end else if (dj_take) begin
               nxt_st = ST_RISE;
               jcnt_d = JCW'(JUMP_FRAMES);
            end
         end
         default: begin
            nxt_st = ST_IDLE;
            jcnt_d = '0;
         end
      endcase
   end

   always_comb begin
      x_d    = '0;
      face_d = facing_left;
      if (key_left) begin
         x_d    = neg10(RUN_POS);
         face_d = 1'b1;
      end else if (key_right) begin
         x_d    = RUN_POS;
         face_d = 1'b0;
      end
      // A grounded swing roots the player in place; airborne swings do not.
      if (attack && ((cur_st == ST_IDLE) || (cur_st == ST_RUN))) begin
         x_d = '0;
      end

      case (nxt_st)
         ST_RISE: y_d = neg10(RISE_POS);
         ST_FALL: y_d = FALL_POS;
         default: y_d = '0;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         cur_st      <= ST_IDLE;
         jump_cnt    <= '0;
         x_motion    <= '0;
         y_motion    <= '0;
         facing_left <= 1'b0;
         prev_jump   <= 1'b0;
         prev_atk    <= 1'b0;
         armed       <= 1'b0;
      end else begin
         cur_st      <= nxt_st;
         jump_cnt    <= jcnt_d;
         x_motion    <= x_d;
         y_motion    <= y_d;
         facing_left <= face_d;
         prev_jump   <= key_jump;
         prev_atk    <= key_atk;
         armed       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl: a vector table for single-frame
// behaviour plus hand-written jump, ceiling, attack, reset and double-jump runs.
module tb_player_action_ctrl;
   import player_pkg::*;

   logic       frame_clk;
   logic       Reset;
   logic [7:0] keycode;
   logic       on_ground;
   logic       hit_ceiling;
   logic [9:0] x_motion;
   logic [9:0] y_motion;
   logic       facing_left;
   logic       attack;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

`ifdef PLAYER_DOUBLE_JUMP_EN
   localparam bit DJ = 1'b1;
`else
   localparam bit DJ = 1'b0;
`endif

   localparam logic [9:0] P2 = 10'h002;
   localparam logic [9:0] M2 = 10'h3FE;
   localparam logic [9:0] P4 = 10'h004;
   localparam logic [9:0] M4 = 10'h3FC;
   localparam logic [9:0] Z  = 10'h000;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_RISE = 3'd2;
   localparam logic [2:0] S_FALL = 3'd3;

   typedef struct {
      logic [7:0] key;
      logic       og;
      logic       hc;
      logic [2:0] st;
      logic [9:0] x;
      logic [9:0] y;
      logic       f;
      logic       a;
   } vec_t;

   vec_t vt[18];

   player_action_ctrl dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .on_ground   (on_ground),
      .hit_ceiling (hit_ceiling),
      .x_motion    (x_motion),
      .y_motion    (y_motion),
      .facing_left (facing_left),
      .attack      (attack),
      .state       (state)
   );

   // clock / reset
   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   // driver tasks
   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] k, input logic og, input logic hc);
      keycode     = k;
      on_ground   = og;
      hit_ceiling = hc;
   endtask

   // scoreboard
   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] e_st, input logic [9:0] e_x,
                            input logic [9:0] e_y, input logic e_f, input logic e_a);
      chk({tag, ".state"}, {7'd0, state}, {7'd0, e_st});
      chk({tag, ".x"}, x_motion, e_x);
      chk({tag, ".y"}, y_motion, e_y);
      chk({tag, ".facing"}, {9'd0, facing_left}, {9'd0, e_f});
      chk({tag, ".attack"}, {9'd0, attack}, {9'd0, e_a});
   endtask

   function automatic logic [9:0] y_of(input logic [2:0] st);
      if (st == S_RISE) return M4;
      if (st == S_FALL) return P4;
      return Z;
   endfunction

   task automatic move(input string tag, input logic [7:0] k, input logic og, input logic hc,
                       input logic [2:0] e_st);
      drive(k, og, hc);
      step();
      chk({tag, ".state"}, {7'd0, state}, {7'd0, e_st});
      chk({tag, ".y"}, y_motion, y_of(e_st));
   endtask

   initial begin
      logic [2:0] e_st;
      logic       e_a;
      logic [7:0] k;

      vt[0]  = '{8'h00, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b0, 1'b0};
      vt[1]  = '{8'h4F, 1'b1, 1'b0, S_RUN,  P2, Z,  1'b0, 1'b0};
      vt[2]  = '{8'h4F, 1'b1, 1'b0, S_RUN,  P2, Z,  1'b0, 1'b0};
      vt[3]  = '{8'h4F, 1'b1, 1'b0, S_RUN,  P2, Z,  1'b0, 1'b0};
      vt[4]  = '{8'h4F, 1'b1, 1'b0, S_RUN,  P2, Z,  1'b0, 1'b0};
      vt[5]  = '{8'h4F, 1'b1, 1'b0, S_RUN,  P2, Z,  1'b0, 1'b0};
      vt[6]  = '{8'h50, 1'b1, 1'b0, S_RUN,  M2, Z,  1'b1, 1'b0};
      vt[7]  = '{8'h00, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};
      vt[8]  = '{8'h00, 1'b0, 1'b0, S_FALL, Z,  P4, 1'b1, 1'b0};
      vt[9]  = '{8'h50, 1'b0, 1'b0, S_FALL, M2, P4, 1'b1, 1'b0};
      vt[10] = '{8'h00, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};
      vt[11] = '{8'h52, 1'b0, 1'b0, S_FALL, Z,  P4, 1'b1, 1'b0};
      vt[12] = '{8'h52, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};
      vt[13] = '{8'h52, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};
      vt[14] = '{8'h00, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};
      vt[15] = '{8'h52, 1'b1, 1'b1, S_RISE, Z,  M4, 1'b1, 1'b0};
      vt[16] = '{8'h52, 1'b0, 1'b1, S_FALL, Z,  P4, 1'b1, 1'b0};
      vt[17] = '{8'h00, 1'b1, 1'b0, S_IDLE, Z,  Z,  1'b1, 1'b0};

      Reset = 1'b1;
      drive(8'h00, 1'b1, 1'b0);
      #12;
      check_out("reset", S_IDLE, Z, Z, 1'b0, 1'b0);
      Reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].key, vt[i].og, vt[i].hc);
         step();
         check_out($sformatf("vec[%0d]", i), vt[i].st, vt[i].x, vt[i].y, vt[i].f, vt[i].a);
      end

      // Held jump key for 40 frames: 24 RISE frames, FALL, land, no re-jump.
      for (int i = 1; i <= 40; i++) begin
         e_st = (i <= 24) ? S_RISE : (i <= 30) ? S_FALL : S_IDLE;
         move($sformatf("hold_jump[%0d]", i), 8'h52, (i == 1 || i >= 31), 1'b0, e_st);
      end

      // Ceiling contact during RISE frame 5 ends the rise on the next frame.
      move("ceil_pre", 8'h00, 1'b1, 1'b0, S_IDLE);
      move("ceil[1]", 8'h52, 1'b1, 1'b0, S_RISE);
      for (int i = 2; i <= 5; i++) begin
         move($sformatf("ceil[%0d]", i), 8'h52, 1'b0, 1'b0, S_RISE);
      end
      move("ceil[6]", 8'h52, 1'b0, 1'b1, S_FALL);
      move("ceil_land", 8'h00, 1'b1, 1'b0, S_IDLE);

      // Swing, ignored presses during cooldown, new swing once ready.
      for (int j = 1; j <= 70; j++) begin
         case (j)
            1, 16, 32, 34: k = 8'h1B;
            6, 7:          k = 8'h4F;
            default:       k = 8'h00;
         endcase
         e_a  = ((j >= 1 && j <= 12) || (j >= 34 && j <= 45));
         e_st = (j == 6 || j == 7) ? S_RUN : S_IDLE;
         drive(k, 1'b1, 1'b0);
         step();
         chk($sformatf("swing[%0d].attack", j), {9'd0, attack}, {9'd0, e_a});
         chk($sformatf("swing[%0d].x", j), x_motion, Z);
         chk($sformatf("swing[%0d].state", j), {7'd0, state}, {7'd0, e_st});
      end

      // Asynchronous reset mid-rise and mid-swing; held jump must not re-fire.
      drive(8'h1B, 1'b1, 1'b0);
      step();
      drive(8'h52, 1'b1, 1'b0);
      step();
      drive(8'h52, 1'b0, 1'b0);
      step();
      chk("pre_rst.state", {7'd0, state}, {7'd0, S_RISE});
      chk("pre_rst.attack", {9'd0, attack}, 10'd1);
      #2;
      Reset = 1'b1;
      #1;
      check_out("mid_rst", S_IDLE, Z, Z, 1'b0, 1'b0);
      #2;
      drive(8'h52, 1'b1, 1'b0);
      Reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check_out($sformatf("post_rst[%0d]", i), S_IDLE, Z, Z, 1'b0, 1'b0);
      end

      // Double jump: second press in FALL, third ignored, re-armed by landing.
      move("dj_a", 8'h00, 1'b1, 1'b0, S_IDLE);
      move("dj_b", 8'h52, 1'b1, 1'b0, S_RISE);
      move("dj_c", 8'h00, 1'b0, 1'b0, S_RISE);
      move("dj_d", 8'h00, 1'b0, 1'b1, S_FALL);
      move("dj_second", 8'h52, 1'b0, 1'b0, DJ ? S_RISE : S_FALL);
      move("dj_e", 8'h00, 1'b0, 1'b0, DJ ? S_RISE : S_FALL);
      move("dj_f", 8'h00, 1'b0, 1'b1, S_FALL);
      move("dj_third", 8'h52, 1'b0, 1'b0, S_FALL);
      move("dj_land", 8'h00, 1'b1, 1'b0, S_IDLE);
      move("dj_g", 8'h52, 1'b1, 1'b0, S_RISE);
      move("dj_h", 8'h00, 1'b0, 1'b1, S_FALL);
      move("dj_rearmed", 8'h52, 1'b0, 1'b0, DJ ? S_RISE : S_FALL);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
